eprisc_bus_master: RTL and testbench

EPRISC_BUS_MASTER -- requirements
Module: epRISC_bus_master

---
 rtl/eprisc_bus_master_if.sv | 27 ++
 rtl/eprisc_bus_master.sv | 132 +++++++++++++
 tb/tb_eprisc_bus_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/eprisc_bus_master_if.sv
// Host request/response and controller bus signals for the epRISC bus master.
// The master modport is the bus master's view; slave is the host/controller side.
interface eprisc_bus_master_if;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWrite;
    logic [14:0] iReqAddr;
    logic [15:0] iReqData;
    logic        oRspValid;
    logic [31:0] oRspData;
    logic        oBusClock;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO;
    logic        iBusInterrupt;
    logic        oInterrupt;

    modport master (
        input  iReqValid, iReqWrite, iReqAddr, iReqData, iBusMISO, iBusInterrupt,
        output oReqReady, oRspValid, oRspData, oBusClock, oBusSelect, oBusMOSI, oInterrupt
    );

    modport slave (
        output iReqValid, iReqWrite, iReqAddr, iReqData, iBusMISO, iBusInterrupt,
        input  oReqReady, oRspValid, oRspData, oBusClock, oBusSelect, oBusMOSI, oInterrupt
    );
endinterface

// File: rtl/eprisc_bus_master.sv
// epRISC I/O bus master: serialises one 32-bit word per 7-period frame; reads send the
// address frame twice and take the controller's reply from the second frame.
module eprisc_bus_master #(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [1:0]  SELECT_CODE = 2'h1
) (
    input logic                 iClk,
    input logic                 iRst,
    eprisc_bus_master_if.master bus
);

    typedef enum logic [2:0] {StResync, StIdle, StWframe, StRaddr, StRdata} state_e;

    localparam logic [7:0] DivLast    = 8'(CLK_DIV - 1);
    localparam logic [9:0] ResyncLast = 10'(4 * CLK_DIV - 1);
    localparam logic [3:0] HalfLast   = 4'd13;

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  half_q, half_d;
    logic [9:0]  resync_q, resync_d;
    logic [31:0] word_q, word_d;
    logic [31:0] stage_q, stage_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  irq_q;

    logic       in_frame, half_end, frame_end, data_half;
    logic [7:0] tx_byte;

    assign in_frame  = (state_q == StWframe) || (state_q == StRaddr) || (state_q == StRdata);
    assign half_end  = (div_q == DivLast);
    assign frame_end = in_frame && half_end && (half_q == HalfLast);
    // Odd half-periods 1,3,5,7 are the high phases of periods 1..4.
    assign data_half = in_frame && half_q[0] && !half_q[3];
    assign tx_byte   = word_q[{half_q[2:1], 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        half_d      = half_q;
        resync_d    = resync_q;
        word_d      = word_q;
        stage_d     = stage_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;

        if (in_frame) begin
            if (half_end) begin
                div_d  = 8'h00;
                half_d = (half_q == HalfLast) ? 4'd0 : half_q + 4'd1;
            end else begin
                div_d = div_q + 8'd1;
            end
            if ((state_q == StRdata) && data_half && half_end) begin
                stage_d[{half_q[2:1], 3'b000} +: 8] = bus.iBusMISO;
            end
        end

        unique case (state_q)
            StResync: begin
                if (resync_q == ResyncLast) begin
                    state_d = StIdle;
                end else begin
                    resync_d = resync_q + 10'd1;
                end
            end
            StIdle: begin
                if (bus.iReqValid) begin
                    word_d  = {bus.iReqWrite, bus.iReqAddr,
                               bus.iReqWrite ? bus.iReqData : 16'h0000};
                    div_d   = 8'h00;
                    half_d  = 4'd0;
                    state_d = bus.iReqWrite ? StWframe : StRaddr;
                end
            end
            StWframe: begin
                if (frame_end) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                end
            end
            StRaddr: begin
                if (frame_end) begin
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (frame_end) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = stage_q;
                end
            end
            default: state_d = StResync;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= StResync;
            div_q       <= 8'h00;
            half_q      <= 4'd0;
            resync_q    <= 10'd0;
            word_q      <= 32'h0;
            stage_q     <= 32'h0;
            rsp_data_q  <= 32'h0;
            rsp_valid_q <= 1'b0;
            irq_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            half_q      <= half_d;
            resync_q    <= resync_d;
            word_q      <= word_d;
            stage_q     <= stage_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            irq_q       <= {irq_q[0], bus.iBusInterrupt};
        end
    end

    // Select low in RESYNC holds the controller in reset so it realigns to the next frame.
    assign bus.oBusSelect = (state_q == StResync) ? 2'h0 : SELECT_CODE;
    assign bus.oReqReady  = (state_q == StIdle);
    assign bus.oRspValid  = rsp_valid_q;
    assign bus.oRspData   = rsp_data_q;
    assign bus.oBusClock  = in_frame && half_q[0];
    assign bus.oBusMOSI   = data_half ? tx_byte : 8'h00;
    assign bus.oInterrupt = irq_q[1];

endmodule

// File: tb/tb_eprisc_bus_master.sv
// Directed bench for eprisc_bus_master at CLK_DIV=2 with a byte-serving controller model.
module tb_eprisc_bus_master;

    localparam int         D   = 2;
    localparam logic [1:0] SEL = 2'h1;

    typedef struct {
        logic        write;
        logic [14:0] addr;
        logic [15:0] data;
        logic [31:0] slave;
        bit          inject;
        logic [31:0] exp_word;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eprisc_bus_master_if bus ();

    eprisc_bus_master #(
        .CLK_DIV    (D),
        .SELECT_CODE(SEL)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] slave_word = 32'h0;
    logic        prev_clk = 1'b0;
    int unsigned slave_idx = 0;
    vec_t        vecs[6];

    // Controller model: presents byte k of its reply from the k-th rising edge of a frame.
    always @(negedge clk) begin
        if (bus.oBusSelect == 2'h0) begin
            slave_idx    <= 0;
            bus.iBusMISO <= 8'h00;
        end else if (bus.oBusClock && !prev_clk) begin
            bus.iBusMISO <= (slave_idx < 4) ? 8'(slave_word >> (8 * slave_idx)) : 8'h00;
            slave_idx    <= (slave_idx == 6) ? 0 : slave_idx + 1;
        end
        prev_clk <= bus.oBusClock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30) $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected {clock, mosi} in cycle n (1-based) after acceptance.
    function automatic logic [8:0] exp_bus(input logic [31:0] w, input int n);
        int          h;
        logic        c;
        logic [31:0] b;
        h = ((n - 1) % (14 * D)) / D;
        c = (h % 2 == 1);
        b = w >> (8 * ((h - 1) / 2));
        return {c, (c && h < 8) ? b[7:0] : 8'h00};
    endfunction

    task automatic present(input vec_t v);
        bus.iReqValid = 1'b1;
        bus.iReqWrite = v.write;
        bus.iReqAddr  = v.addr;
        bus.iReqData  = v.data;
        slave_word    = v.slave;
    endtask

    // Entered at a negedge with the request already presented.
    task automatic run_txn(input vec_t v);
        chk("accept_ready", 64'(bus.oReqReady), 64'(1'b1));
        @(posedge clk);
        #1 bus.iReqValid = 1'b0;
        for (int n = 1; n < v.exp_lat; n++) begin
            @(negedge clk);
            chk("frame_bus", {bus.oBusClock, bus.oBusMOSI, bus.oRspValid, bus.oReqReady,
                              bus.oBusSelect}, {exp_bus(v.exp_word, n), 1'b0, 1'b0, SEL});
            if (v.inject && n == 7) begin
                bus.iReqValid = 1'b1;
                bus.iReqWrite = ~v.write;
                bus.iReqAddr  = 15'h2AAA;
                bus.iReqData  = 16'h5555;
            end
            if (v.inject && n == 8) bus.iReqValid = 1'b0;
        end
        @(negedge clk);
        chk("rsp_valid_ready", {bus.oRspValid, bus.oReqReady, bus.oBusClock}, 3'b110);
        chk("rsp_data", 64'(bus.oRspData), 64'(v.exp_data));
    endtask

    // Entered just after the edge where iRst was dropped.
    task automatic release_check();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("post_reset_zero", {bus.oBusSelect, bus.oBusClock, bus.oBusMOSI,
                    bus.oReqReady, bus.oRspValid, bus.oRspData, bus.oInterrupt}, 64'h0);
            end
            chk("resync_ready", {bus.oReqReady, bus.oBusSelect, bus.oRspValid},
                {(i == 8), (i == 8) ? SEL : 2'h0, 1'b0});
        end
    endtask

    initial begin
        vec_t cv;

        vecs[0] = '{1'b1, 15'h0045, 16'hBEEF, 32'h0,         1'b0, 32'h8045BEEF, 29, 32'h00000000};
        vecs[1] = '{1'b0, 15'h0040, 16'h1111, 32'h12345678, 1'b0, 32'h00400000, 57, 32'h12345678};
        vecs[2] = '{1'b1, 15'h7FFF, 16'h0001, 32'h0,         1'b0, 32'hFFFF0001, 29, 32'h12345678};
        vecs[3] = '{1'b0, 15'h7FFF, 16'hFFFF, 32'hA5C30F96, 1'b0, 32'h7FFF0000, 57, 32'hA5C30F96};
        vecs[4] = '{1'b1, 15'h0000, 16'h0000, 32'h0,         1'b1, 32'h80000000, 29, 32'hA5C30F96};
        vecs[5] = '{1'b0, 15'h1234, 16'h0000, 32'h00FF00FF, 1'b1, 32'h12340000, 57, 32'h00FF00FF};

        bus.iReqValid     = 1'b0;
        bus.iReqWrite     = 1'b0;
        bus.iReqAddr      = 15'h0;
        bus.iReqData      = 16'h0;
        bus.iBusInterrupt = 1'b0;

        repeat (2) begin
            @(negedge clk);
            chk("reset_zero", {bus.oBusSelect, bus.oBusClock, bus.oBusMOSI, bus.oReqReady,
                bus.oRspValid, bus.oRspData, bus.oInterrupt}, 64'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        release_check();

        // Interrupt synchroniser latency
        @(negedge clk) bus.iBusInterrupt = 1'b1;
        @(negedge clk) chk("irq_rise_1", 64'(bus.oInterrupt), 64'(1'b0));
        @(negedge clk) chk("irq_rise_2", 64'(bus.oInterrupt), 64'(1'b1));
        bus.iBusInterrupt = 1'b0;
        @(negedge clk) chk("irq_fall_1", 64'(bus.oInterrupt), 64'(1'b1));
        @(negedge clk) chk("irq_fall_2", 64'(bus.oInterrupt), 64'(1'b0));

        foreach (vecs[i]) begin
            @(negedge clk);
            present(vecs[i]);
            run_txn(vecs[i]);
            @(negedge clk);
            chk("post_idle", {bus.oRspValid, bus.oReqReady, bus.oBusClock}, 3'b010);
        end

        // Back-to-back: next request is presented in the response cycle
        @(negedge clk);
        cv = vecs[2];
        cv.exp_data = 32'h00FF00FF;
        present(cv);
        run_txn(cv);
        present(vecs[1]);
        run_txn(vecs[1]);
        @(negedge clk);
        chk("chain_idle", {bus.oRspValid, bus.oReqReady, bus.oBusClock}, 3'b010);

        // Reset during period 3 of a write frame
        @(negedge clk);
        present(vecs[0]);
        chk("abort_accept_ready", 64'(bus.oReqReady), 64'(1'b1));
        @(posedge clk);
        #1 bus.iReqValid = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            chk("abort_frame_bus", {bus.oBusClock, bus.oBusMOSI}, exp_bus(vecs[0].exp_word, n));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_zero", {bus.oBusSelect, bus.oBusClock, bus.oBusMOSI, bus.oRspValid,
                           bus.oReqReady}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        release_check();
        repeat (20) begin
            @(negedge clk);
            chk("no_late_rsp", {bus.oRspValid, bus.oBusClock, bus.oReqReady}, 3'b001);
        end

        // Recovery after the aborted frame
        present(vecs[0]);
        run_txn(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
